// File: rtl/z80_bus_bridge_if.sv
// Z80 bus bridge interface: CPU strobes/address/data, RAM port, IO port.
// slave = bridge view, master = CPU/memory/IO environment view.
interface z80_bus_bridge_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_m1_n;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_rfsh_n;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n;
    logic [15:0] ram_addr;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_wstb;
    logic        io_rstb;
    logic [7:0]  io_rdata;
    logic        busy;

    modport slave (
        input  cpu_a, cpu_do, cpu_m1_n, cpu_mreq_n, cpu_iorq_n,
        input  cpu_rd_n, cpu_wr_n, cpu_rfsh_n, ram_rdata, io_rdata,
        output cpu_di, cpu_wait_n, ram_addr, ram_en, ram_we,
        output ram_wdata, io_addr, io_wdata, io_wstb, io_rstb, busy
    );

    modport master (
        output cpu_a, cpu_do, cpu_m1_n, cpu_mreq_n, cpu_iorq_n,
        output cpu_rd_n, cpu_wr_n, cpu_rfsh_n, ram_rdata, io_rdata,
        input  cpu_di, cpu_wait_n, ram_addr, ram_en, ram_we,
        input  ram_wdata, io_addr, io_wdata, io_wstb, io_rstb, busy
    );
endinterface

// File: rtl/z80_bus_bridge.sv
// Z80 bus bridge: turns CPU bus cycles into single RAM/IO strobes with waits.
// Ports: clk, reset_n (async, active-low), bus (z80_bus_bridge_if.slave).
// Param WAIT_STATES (0..7). Macro Z80_BRIDGE_IO_EN enables IO-space access.
module z80_bus_bridge #(
    parameter int WAIT_STATES = 1
) (
    input logic             clk,
    input logic             reset_n,
    z80_bus_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT, ACCESS, CAPTURE, HOLD
    } state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  di_q;
    logic        is_io_q;
    logic        is_wr_q;
    logic        mem_req, io_req, intack, start;

    assign mem_req = !bus.cpu_mreq_n && bus.cpu_rfsh_n &&
                     (!bus.cpu_rd_n || !bus.cpu_wr_n);
`ifdef Z80_BRIDGE_IO_EN
    assign io_req  = !bus.cpu_iorq_n && bus.cpu_m1_n &&
                     (!bus.cpu_rd_n || !bus.cpu_wr_n);
`else
    assign io_req  = 1'b0;
`endif
    assign intack  = !bus.cpu_iorq_n && !bus.cpu_m1_n;
    // Memory wins when both mreq and iorq are low.
    assign start   = mem_req || io_req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = (WS == 3'd0) ? ACCESS : WAIT;
                else if (intack)
                    state_d = HOLD;
            end
            WAIT:    if (cnt_q <= 3'd1) state_d = ACCESS;
            ACCESS:  state_d = is_wr_q ? HOLD : CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD: begin
                if (bus.cpu_mreq_n && bus.cpu_iorq_n)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            di_q    <= 8'h00;
            is_io_q <= 1'b0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                cnt_q   <= WS;
                addr_q  <= bus.cpu_a;
                data_q  <= bus.cpu_do;
                is_io_q <= !mem_req;
                is_wr_q <= !bus.cpu_wr_n;
            end else if (state_q == IDLE && intack) begin
                di_q <= 8'hFF;
            end else if (state_q == WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end else if (state_q == CAPTURE) begin
                di_q <= is_io_q ? bus.io_rdata : bus.ram_rdata;
            end
        end
    end

    assign bus.cpu_di     = di_q;
    assign bus.cpu_wait_n = !(state_q == WAIT && cnt_q != 3'd0);
    assign bus.busy       = (state_q != IDLE);
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = data_q;
    assign bus.ram_en     = (state_q == ACCESS) && !is_io_q;
    assign bus.ram_we     = (state_q == ACCESS) && !is_io_q && is_wr_q;
`ifdef Z80_BRIDGE_IO_EN
    assign bus.io_addr    = addr_q[7:0];
    assign bus.io_wdata   = data_q;
    assign bus.io_wstb    = (state_q == ACCESS) && is_io_q && is_wr_q;
    assign bus.io_rstb    = (state_q == ACCESS) && is_io_q && !is_wr_q;
`else
    assign bus.io_addr    = 8'h00;
    assign bus.io_wdata   = 8'h00;
    assign bus.io_wstb    = 1'b0;
    assign bus.io_rstb    = 1'b0;
`endif
endmodule
